// File: rtl/sha_pkg.sv
// Shared types and constants for the nonce scanner: scan length, FSM states and
// the layout of the second status word.
package sha_pkg;

    localparam int unsigned NUM_NONCES = 16;
    localparam int unsigned NONCE_W    = 4;

    // Second status word: {found, 27'b0, best_nonce}
    localparam int unsigned FOUND_BIT  = 31;
    localparam int unsigned NONCE_MSB  = 3;
    localparam int unsigned NONCE_LSB  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWr0,
        StWr1
    } state_e;

endpackage

// File: rtl/best_tracker.sv
// Running minimum over a stream of hash words, with the index of the first
// minimum and a flag telling whether that minimum beats the target.
module best_tracker
    import sha_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               valid,
    input  logic [NONCE_W-1:0] idx,
    input  logic [31:0]        value,
    input  logic [31:0]        target,
    output logic [31:0]        best_hash,
    output logic [NONCE_W-1:0] best_nonce,
    output logic               found
);

    logic [31:0]        best_hash_q, best_hash_d;
    logic [NONCE_W-1:0] best_nonce_q, best_nonce_d;
    logic               found_q, found_d;

    always_comb begin
        best_hash_d  = best_hash_q;
        best_nonce_d = best_nonce_q;
        found_d      = found_q;
        if (clear) begin
            best_hash_d  = 32'hFFFF_FFFF;
            best_nonce_d = '0;
            found_d      = 1'b0;
        end else if (valid && (value < best_hash_q)) begin
            // Strict compare so an equal later hash never displaces an earlier one
            best_hash_d  = value;
            best_nonce_d = idx;
            found_d      = (value < target);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_hash_q  <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
            found_q      <= 1'b0;
        end else begin
            best_hash_q  <= best_hash_d;
            best_nonce_q <= best_nonce_d;
            found_q      <= found_d;
        end
    end

    assign best_hash  = best_hash_q;
    assign best_nonce = best_nonce_q;
    assign found      = found_q;

endmodule

// File: rtl/nonce_select.sv
// Scans NUM_NONCES hash words from memory, keeps the smallest one and writes a
// two-word status record {best_hash}, {found, best_nonce} back to memory.
module nonce_select #(
    parameter int unsigned NUM_NONCES = sha_pkg::NUM_NONCES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] status_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [3:0]  best_nonce,
    output logic [31:0] best_hash
);

    import sha_pkg::*;

    localparam logic [15:0] LastIdx = 16'(NUM_NONCES - 1);

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] res_base_q, res_base_d;
    logic [15:0] stat_base_q, stat_base_d;
    logic [31:0] target_q, target_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic        clear;
    logic        valid;
    logic [31:0] status_word;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        res_base_d  = res_base_q;
        stat_base_d = stat_base_q;
        target_d    = target_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        clear       = 1'b0;
        valid       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StAddr;
                    target_d    = target;
                    res_base_d  = result_addr;
                    stat_base_d = status_addr;
                    idx_d       = '0;
                    clear       = 1'b1;
                    mem_addr_d  = result_addr;
                    mem_we_d    = 1'b0;
                end
            end
            StAddr: state_d = StData;
            StData: begin
                // Read data for the address presented in StAddr is valid now
                valid = 1'b1;
                if (idx_q < LastIdx) begin
                    idx_d      = idx_q + 16'd1;
                    mem_addr_d = res_base_q + idx_q + 16'd1;
                    state_d    = StAddr;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = stat_base_q;
                    state_d    = StWr0;
                end
            end
            StWr0: begin
                mem_addr_d = stat_base_q + 16'd1;
                state_d    = StWr1;
            end
            StWr1: begin
                mem_we_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            res_base_q  <= '0;
            stat_base_q <= '0;
            target_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            res_base_q  <= res_base_d;
            stat_base_q <= stat_base_d;
            target_q    <= target_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
        end
    end

    best_tracker u_best_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .valid      (valid),
        .idx        (idx_q[NONCE_W-1:0]),
        .value      (mem_read_data),
        .target     (target_q),
        .best_hash  (best_hash),
        .best_nonce (best_nonce),
        .found      (found)
    );

    always_comb begin
        status_word                      = '0;
        status_word[FOUND_BIT]           = found;
        status_word[NONCE_MSB:NONCE_LSB] = best_nonce;
    end

    // Write data is a state-decoded select of registered values
    always_comb begin
        case (state_q)
            StWr0:   mem_write_data = best_hash;
            StWr1:   mem_write_data = status_word;
            default: mem_write_data = '0;
        endcase
    end

    assign done     = (state_q == StIdle);
    assign mem_clk  = clk;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_nonce_select.sv
// Bench for nonce_select: vector table of scans, plus reset-abort and
// back-to-back start sequences; status writes are checked against a queue.
module tb_nonce_select;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] result_addr;
    logic [15:0] status_addr;
    logic [31:0] target;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        found;
    logic [3:0]  best_nonce;
    logic [31:0] best_hash;

    always #5 clk = ~clk;

    nonce_select #(.NUM_NONCES(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .result_addr    (result_addr),
        .status_addr    (status_addr),
        .target         (target),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .found          (found),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash)
    );

    // Memory with one-cycle read latency; bench preload port has priority.
    logic [31:0] mem [65536];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;

    always @(posedge mem_clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          pat;
        logic [15:0] ra;
        logic [15:0] sa;
        logic [31:0] tgt;
        logic        f;
        logic [3:0]  n;
        logic [31:0] h;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        vecs[7];
    logic [31:0] hashes[16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every DUT write must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            wr_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%04h data 0x%08h, required no write",
                         mem_addr, mem_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_write_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL status_write: got 0x%04h/0x%08h, required 0x%04h/0x%08h",
                             mem_addr, mem_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic void set_pattern(input int pat);
        for (int k = 0; k < 16; k++) begin
            case (pat)
                0: hashes[k] = (32'(k) << 24) + 32'd5;
                1: hashes[k] = (k == 9) ? 32'h0000_0100 : 32'h8000_0000;
                2: hashes[k] = (k == 3 || k == 12) ? 32'h0000_0010 : 32'h0000_1000 + 32'(k);
                3: hashes[k] = 32'h0000_0500 - 32'(k) * 32'h10;
                4: hashes[k] = 32'hFFFF_FFFF;
                default: hashes[k] = (k == 6) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            endcase
        end
    endfunction

    task automatic load_word(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic load_hashes(input logic [15:0] ra);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tb_we   = 1'b1;
            tb_addr = ra + 16'(k);
            tb_data = hashes[k];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
        check({tag, "_found"}, {31'd0, found}, 32'd0);
        check({tag, "_best_nonce"}, {28'd0, best_nonce}, 32'd0);
        check({tag, "_best_hash"}, best_hash, 32'hFFFF_FFFF);
    endtask

    // Called on the negedge after a start edge; returns clocks until done rises.
    task automatic wait_done(input logic [15:0] ra, output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles % 2 == 1 && cycles < 32)
                check("read_addr", {16'd0, mem_addr}, {16'd0, ra + 16'((cycles - 1) / 2)});
            if (done) break;
        end
    endtask

    task automatic start_scan();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("done_fall", {31'd0, done}, 32'd0);
    endtask

    task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tgt,
                            input logic f, input logic [3:0] n, input logic [31:0] h);
        int          cyc;
        logic [31:0] w1;
        w1 = {f, 27'd0, n};
        load_hashes(ra);
        result_addr = ra;
        status_addr = sa;
        target      = tgt;
        exp_q.push_back('{addr: sa, data: h});
        exp_q.push_back('{addr: sa + 16'd1, data: w1});
        start_scan();
        wait_done(ra, cyc);
        check("latency", 32'(cyc), 32'd34);
        check("found", {31'd0, found}, {31'd0, f});
        check("best_nonce", {28'd0, best_nonce}, {28'd0, n});
        check("best_hash", best_hash, h);
        check("status_word0", mem[sa], h);
        check("status_word1", mem[sa + 16'd1], w1);
        // Inputs change while idle; results must hold
        target      = ~tgt;
        result_addr = ra + 16'h0100;
        repeat (3) @(negedge clk);
        check("hold_hash", best_hash, h);
        check("hold_found", {31'd0, found}, {31'd0, f});
        check("hold_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int          cyc;
        int          w0;
        logic [31:0] mh;
        logic [3:0]  mn;
        logic [31:0] mt;

        reset_n     = 1'b0;
        start       = 1'b0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;
        result_addr = '0;
        status_addr = '0;
        target      = '0;

        vecs[0] = '{pat: 0, ra: 16'h0100, sa: 16'h0200, tgt: 32'h0080_0000,
                    f: 1'b1, n: 4'd0, h: 32'h0000_0005};
        vecs[1] = '{pat: 1, ra: 16'h0100, sa: 16'h0200, tgt: 32'h0000_0100,
                    f: 1'b0, n: 4'd9, h: 32'h0000_0100};
        vecs[2] = '{pat: 2, ra: 16'h2000, sa: 16'h0210, tgt: 32'h0000_0020,
                    f: 1'b1, n: 4'd3, h: 32'h0000_0010};
        vecs[3] = '{pat: 3, ra: 16'hFFF8, sa: 16'h0300, tgt: 32'h0000_0000,
                    f: 1'b0, n: 4'd15, h: 32'h0000_0410};
        vecs[4] = '{pat: 4, ra: 16'h0100, sa: 16'h0200, tgt: 32'hFFFF_FFFF,
                    f: 1'b0, n: 4'd0, h: 32'hFFFF_FFFF};
        vecs[5] = '{pat: 5, ra: 16'h0100, sa: 16'h0200, tgt: 32'hFFFF_FFFF,
                    f: 1'b1, n: 4'd6, h: 32'hFFFF_FFFE};
        vecs[6] = '{pat: 0, ra: 16'h1000, sa: 16'hFFFF, tgt: 32'h0080_0000,
                    f: 1'b1, n: 4'd0, h: 32'h0000_0005};

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd1);

        foreach (vecs[v]) begin
            set_pattern(vecs[v].pat);
            run_scan(vecs[v].ra, vecs[v].sa, vecs[v].tgt, vecs[v].f, vecs[v].n, vecs[v].h);
        end

        // Random hashes with a forced tie, checked against a plain minimum scan
        for (int k = 0; k < 16; k++) hashes[k] = $urandom;
        hashes[11] = hashes[4];
        mt = $urandom;
        mh = 32'hFFFF_FFFF;
        mn = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (hashes[k] < mh) begin
                mh = hashes[k];
                mn = 4'(k);
            end
        end
        run_scan(16'h7FF0, 16'h0500, mt, (mh < mt), mn, mh);

        // Reset during DATA of i=7: no write, outputs cleared, then a clean rescan
        set_pattern(0);
        load_hashes(16'h0100);
        load_word(16'h0200, 32'hDEAD_BEEF);
        load_word(16'h0201, 32'hDEAD_BEEF);
        result_addr = 16'h0100;
        status_addr = 16'h0200;
        target      = 32'h0080_0000;
        start_scan();
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("pre_abort_addr", {16'd0, mem_addr}, 32'h0000_0107);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        check("abort_done_held", {31'd0, done}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_no_write0", mem[16'h0200], 32'hDEAD_BEEF);
        check("abort_no_write1", mem[16'h0201], 32'hDEAD_BEEF);
        run_scan(16'h0100, 16'h0200, 32'h0080_0000, 1'b1, 4'd0, 32'h0000_0005);

        // Start held high: two back-to-back scans with one idle cycle between
        set_pattern(1);
        load_hashes(16'h0100);
        result_addr = 16'h0100;
        status_addr = 16'h0400;
        target      = 32'h0000_0100;
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back('{addr: 16'h0400, data: 32'h0000_0100});
            exp_q.push_back('{addr: 16'h0401, data: 32'h0000_0009});
        end
        w0 = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_fall", {31'd0, done}, 32'd0);
        wait_done(16'h0100, cyc);
        check("b2b_latency0", 32'(cyc), 32'd34);
        check("b2b_writes0", 32'(wr_count - w0), 32'd2);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_one_cycle", {31'd0, done}, 32'd0);
        wait_done(16'h0100, cyc);
        start = 1'b0;
        check("b2b_latency1", 32'(cyc), 32'd34);
        check("b2b_writes1", 32'(wr_count - w0), 32'd4);
        check("b2b_nonce", {28'd0, best_nonce}, 32'd9);
        check("b2b_found", {31'd0, found}, 32'd0);
        repeat (2) @(negedge clk);
        check("b2b_stays_idle", {31'd0, done}, 32'd1);
        check("writes_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
